// File: rtl/snn_pkg.sv
// Shared arithmetic definitions for the synapse driver and the LIF neuron.
package snn_pkg;

  localparam int CURRENT_W = 16;
  localparam int FRAC_SHIFT = 16;
  localparam logic [CURRENT_W-1:0] CURRENT_MAX = 16'hFFFF;

  typedef logic [CURRENT_W-1:0] current_t;

  // Result of one accumulator step: the clipped current and whether it clipped.
  typedef struct packed {
    current_t value;
    logic     sat;
  } acc_result_t;

  // Leak removed by one tick: upper half of current * Q0.16 decay fraction.
  function automatic current_t leak_of(current_t cur, logic [15:0] decay);
    logic [2*CURRENT_W-1:0] product;
    product = (2*CURRENT_W)'(cur) * (2*CURRENT_W)'(decay);
    return product[2*CURRENT_W-1:FRAC_SHIFT];
  endfunction

  // Leaky, saturating accumulate. leak never exceeds cur, so the
  // subtraction cannot wrap; only the weight addition can overflow.
  function automatic acc_result_t acc_step(current_t cur, current_t leak, current_t w);
    logic [CURRENT_W:0] sum;
    acc_result_t        res;
    sum = (CURRENT_W+1)'(cur - leak) + (CURRENT_W+1)'(w);
    res.sat   = sum[CURRENT_W];
    res.value = sum[CURRENT_W] ? CURRENT_MAX : sum[CURRENT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/aer_synapse_driver_if.sv
// AER event handshake plus the weight-table write port of the synapse driver.
interface aer_synapse_driver_if #(
  parameter int ADDR_W = 4
) ();

  logic              aer_valid;
  logic [ADDR_W-1:0] aer_addr;
  logic              aer_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  // Event source / weight programmer side.
  modport master (
    output aer_valid, aer_addr, wr_en, wr_addr, wr_data,
    input  aer_ready
  );

  // Synapse driver side.
  modport slave (
    input  aer_valid, aer_addr, wr_en, wr_addr, wr_data,
    output aer_ready
  );

endinterface

// File: rtl/aer_fifo.sv
// Small synchronous FIFO; full/empty come from an extra wrap bit on each pointer.
module aer_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; the wrap bit distinguishes full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage write.
  // NOTE: the storage array has no reset; empty guards every read, so stale
  // contents are never observed and the array can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/aer_synapse_driver.sv
// Converts buffered AER spike events into a leaky, saturating synaptic current.
module aer_synapse_driver
  import snn_pkg::*;
#(
  parameter int N_SRC      = 16,
  parameter int ADDR_W     = $clog2(N_SRC),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  aer_synapse_driver_if.slave   bus,
  input  logic [15:0]           decay_factor,
  input  logic                  tick,
  input  logic                  hold,
  output current_t              input_current,
  output logic                  sat
);

  logic [15:0]       weight_q [N_SRC];
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop_en;
  logic [ADDR_W-1:0] head_addr;
  current_t          w;
  current_t          leak;
  acc_result_t       acc_next;

  assign bus.aer_ready = !fifo_full;
  assign pop_en        = !fifo_empty && !hold;

  aer_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (bus.aer_valid),
    .push_data (bus.aer_addr),
    .pop       (pop_en),
    .pop_data  (head_addr),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Weight lookup for the popped event and leak for this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a value unassigned and infers a latch.
    w    = '0;
    leak = '0;
    if (pop_en && (32'(head_addr) < N_SRC)) w = weight_q[head_addr];
    if (tick) leak = leak_of(input_current, decay_factor);
    acc_next = acc_step(input_current, leak, w);
  end

  // Weight table write; weights must read zero after reset, so they are cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SRC; i++) weight_q[i] <= '0;
    end else if (bus.wr_en && (32'(bus.wr_addr) < N_SRC)) begin
      weight_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Accumulator: frozen under hold, otherwise leak then add the popped weight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      input_current <= '0;
      sat           <= 1'b0;
    end else if (hold) begin
      sat <= 1'b0;
    end else begin
      input_current <= acc_next.value;
      sat           <= acc_next.sat;
    end
  end

endmodule

// File: tb/tb_aer_synapse_driver.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based behavioural model of the synapse driver.
module tb_aer_synapse_driver;

  localparam int N_SRC = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic [15:0] decay_factor;
  logic        tick;
  logic        hold;
  logic [15:0] input_current;
  logic        sat;

  aer_synapse_driver_if #(.ADDR_W(ADDR_W)) bus ();

  aer_synapse_driver #(
    .N_SRC      (N_SRC),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .decay_factor  (decay_factor),
    .tick          (tick),
    .hold          (hold),
    .input_current (input_current),
    .sat           (sat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model: weight array, event queue, current as plain integers.
  int m_w [N_SRC];
  int m_q [$];
  int m_cur;
  bit m_sat;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_SRC; i++) m_w[i] = 0;
    m_q.delete();
    m_cur = 0;
    m_sat = 0;
  endtask

  task automatic compare_all();
    check("aer_ready", 32'(bus.aer_ready), 32'(m_q.size() < DEPTH));
    check("input_current", 32'(input_current), 32'(m_cur));
    check("sat", 32'(sat), 32'(m_sat));
  endtask

  // One clock cycle: drive at the falling edge, advance the model, compare at the next falling edge.
  task automatic cycle(input logic v, input logic [3:0] a, input logic we,
                       input logic [3:0] wa, input logic [15:0] wd,
                       input logic [15:0] df, input logic tk, input logic hd);
    int     sz;
    bit     acc;
    int     wt;
    longint lk;
    longint s;
    bus.aer_valid = v;
    bus.aer_addr  = a;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    decay_factor  = df;
    tick          = tk;
    hold          = hd;
    sz  = m_q.size();
    acc = v && (sz < DEPTH);
    if (!hd) begin
      wt = 0;
      if (sz > 0) begin
        wt = m_w[m_q[0]];
        void'(m_q.pop_front());
      end
      lk = tk ? ((longint'(m_cur) * longint'(df)) >> 16) : 0;
      s  = longint'(m_cur) - lk + longint'(wt);
      if (s > 65535) begin
        m_cur = 65535;
        m_sat = 1;
      end else begin
        m_cur = int'(s);
        m_sat = 0;
      end
    end else begin
      m_sat = 0;
    end
    if (acc) m_q.push_back(int'(a));
    if (we) m_w[wa] = int'(wd);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [3:0] wa, input logic [15:0] wd);
    cycle(0, 0, 1, wa, wd, 0, 0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    bus.aer_valid = 0;
    bus.wr_en     = 0;
    tick          = 0;
    hold          = 0;
    #1 reset_n = 0;
    #1;
    model_clear();
    check("rst_current", 32'(input_current), 32'h0);
    check("rst_sat", 32'(sat), 32'h0);
    check("rst_ready", 32'(bus.aer_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    clk = 0;
    reset_n = 0;
    bus.aer_valid = 0;
    bus.aer_addr  = 0;
    bus.wr_en     = 0;
    bus.wr_addr   = 0;
    bus.wr_data   = 0;
    decay_factor  = 0;
    tick          = 0;
    hold          = 0;
    model_clear();
    #1;
    check("init_current", 32'(input_current), 32'h0);
    check("init_ready", 32'(bus.aer_ready), 32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1;

    // Reset with events queued: buffered events and weights are discarded.
    wr(7, 16'h0055);
    cycle(1, 7, 0, 0, 0, 0, 0, 1);
    cycle(1, 7, 0, 0, 0, 0, 0, 1);
    do_reset();
    cycle(1, 7, 0, 0, 0, 0, 0, 0);
    idle(2);
    check("rst_event_adds_zero", 32'(input_current), 32'h0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("addr0_adds_zero", 32'(input_current), 32'h0);

    // Single event: visible one edge after acceptance, then steady.
    wr(3, 16'h0100);
    cycle(1, 3, 0, 0, 0, 0, 0, 0);
    check("single_latency", 32'(input_current), 32'h0);
    idle(1);
    check("single_dut", 32'(input_current), 32'h0100);
    check("single_model", 32'(m_cur), 32'h0100);
    idle(3);
    check("single_steady", 32'(input_current), 32'h0100);

    // Decay: bring current to 0x8000, then halve it twice.
    wr(5, 16'h7F00);
    cycle(1, 5, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("decay_start", 32'(input_current), 32'h8000);
    cycle(0, 0, 0, 0, 0, 16'h8000, 1, 0);
    check("decay_1_dut", 32'(input_current), 32'h4000);
    check("decay_1_model", 32'(m_cur), 32'h4000);
    cycle(0, 0, 0, 0, 0, 16'h8000, 1, 0);
    check("decay_2_dut", 32'(input_current), 32'h2000);
    cycle(0, 0, 0, 0, 0, 16'h8000, 1, 1);
    check("decay_hold_ignored", 32'(input_current), 32'h2000);

    // Saturation: two back-to-back 0xF000 events.
    do_reset();
    wr(1, 16'hF000);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check("sat_first", 32'(input_current), 32'hF000);
    check("sat_first_flag", 32'(sat), 32'h0);
    idle(1);
    check("sat_clip", 32'(input_current), 32'hFFFF);
    check("sat_pulse", 32'(sat), 32'h1);
    check("sat_model", 32'(m_sat), 32'h1);
    idle(1);
    check("sat_pulse_end", 32'(sat), 32'h0);
    check("sat_hold_value", 32'(input_current), 32'hFFFF);

    // Backpressure: fill under hold, stall the 5th, then drain.
    do_reset();
    wr(4, 16'h0001);
    for (int i = 0; i < 4; i++) cycle(1, 4, 0, 0, 0, 0, 0, 1);
    check("bp_full", 32'(bus.aer_ready), 32'h0);
    check("bp_held_current", 32'(input_current), 32'h0);
    cycle(1, 4, 0, 0, 0, 0, 0, 1);
    check("bp_stall", 32'(bus.aer_ready), 32'h0);
    cycle(1, 4, 0, 0, 0, 0, 0, 0);
    check("bp_first_pop", 32'(input_current), 32'h1);
    check("bp_ready_back", 32'(bus.aer_ready), 32'h1);
    cycle(1, 4, 0, 0, 0, 0, 0, 0);
    idle(4);
    check("bp_total_dut", 32'(input_current), 32'h5);
    check("bp_total_model", 32'(m_cur), 32'h5);

    // Write collision: pop of addr 2 while W[2] is rewritten uses the old weight.
    do_reset();
    wr(2, 16'h0010);
    cycle(1, 2, 0, 0, 0, 0, 0, 0);
    wr(2, 16'h0020);
    check("collide_old", 32'(input_current), 32'h0010);
    cycle(1, 2, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("collide_new", 32'(input_current), 32'h0030);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        v, we, tk, hd;
      logic [3:0]  a, wa;
      logic [15:0] wd, df;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        v  = ($urandom_range(0, 9) < 7);
        a  = 4'($urandom_range(0, N_SRC - 1));
        we = ($urandom_range(0, 9) == 0);
        wa = 4'($urandom_range(0, N_SRC - 1));
        wd = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0FFF));
        df = 16'($urandom);
        tk = ($urandom_range(0, 9) == 0);
        hd = ($urandom_range(0, 3) == 0);
        cycle(v, a, we, wa, wd, df, tk, hd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
